exec_control: RTL and testbench

EXEC_CONTROL -- requirements
Module: exec_control

---
 rtl/exec_pkg.sv | 54 +++++
 rtl/alu_decoder.sv | 24 ++
 rtl/exec_control.sv | 209 ++++++++++++++++++++
 tb/tb_exec_control.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the multicycle execution controller.
// States, opcodes, functs and ALU operation codes.
package exec_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEXE = 4'd9,
    S_JUMP    = 4'd10,
    S_HALT    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that wait on mem_ready and are guarded by the timeout counter
  function automatic logic is_wait(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) ||
           (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation decoder.
// valid_o flags functs the datapath can execute.
module alu_decoder
  import exec_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] aluop_o,
  output logic       valid_o
);

  always_comb begin
    aluop_o = ALU_ADD;
    valid_o = 1'b1;
    unique case (1'b1)
      (funct_i == F_ADD): aluop_o = ALU_ADD;
      (funct_i == F_SUB): aluop_o = ALU_SUB;
      (funct_i == F_AND): aluop_o = ALU_AND;
      (funct_i == F_OR):  aluop_o = ALU_OR;
      (funct_i == F_SLT): aluop_o = ALU_SLT;
      default:            valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_control.sv
// Multicycle execution control FSM with memory
// timeout watchdog and illegal-instruction detection.
module exec_control
  import exec_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  ALUop,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic        fault,
  output logic [3:0]  state
);

  localparam int CW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [2:0] rt_aluop;
  logic       funct_ok;
  logic       op_ok;
  logic       unused_instr;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            fault_q, fault_d;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  alu_decoder u_alu_dec (
    .funct_i (funct),
    .aluop_o (rt_aluop),
    .valid_o (funct_ok)
  );

  assign op_ok =
    (opcode inside {OP_RTYPE, OP_J, OP_BEQ,
                    OP_ADDI, OP_LW, OP_SW}) &&
    ((opcode != OP_RTYPE) || funct_ok);

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    unique case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FETCH;
        if (op_ok) begin
          unique case (1'b1)
            (opcode == OP_LW),
            (opcode == OP_SW):    state_d = S_MEMADR;
            (opcode == OP_RTYPE): state_d = S_RTEXE;
            (opcode == OP_BEQ):   state_d = S_BEQ;
            (opcode == OP_ADDI):  state_d = S_ADDIEXE;
            (opcode == OP_J):     state_d = S_JUMP;
            default:              state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:
        state_d = (opcode == OP_SW) ? S_MEMWR :
                  (opcode == OP_LW) ? S_MEMRD : S_FETCH;
      S_MEMRD:
        if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:
        if (mem_ready) state_d = S_FETCH;
      S_RTEXE:   state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_ADDIEXE: state_d = S_ALUWB;
      S_BEQ:     state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase

    // A ready arriving on the timeout cycle still completes the access
    if (is_wait(state_q)) begin
      if (mem_ready) begin
        cnt_d = '0;
      end else if (cnt_inc == CW'(TIMEOUT)) begin
        state_d = S_HALT;
        fault_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    if ((state_d != state_q) && is_wait(state_d))
      cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    ALUop      = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PC_ALU;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        illegal   = !op_ok;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_RTEXE: begin
        alu_src_a = 1'b1;
        ALUop     = rt_aluop;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_RTYPE);
      end
      S_ADDIEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        ALUop     = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
      end
      S_HALT:  ;
      default: ;
    endcase

    // Request and write strobes drop the moment reset is applied
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_exec_control.sv
// Directed scoreboard bench for exec_control.
// Expected output bundles are queued per cycle and popped on sampling.
module tb_exec_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  ALUop;
  logic        mem_read, mem_write, iord;
  logic        ir_write, pc_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic        illegal, fault;
  logic [3:0]  state;

  exec_control #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ALUop      (ALUop),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .fault      (fault),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic mr, mw, iord, irw, pcw, rw, rdst, m2r, asa;
    logic [1:0] asb, pcs;
    logic ill, flt;
  } out_t;

  typedef struct {
    string tag;
    out_t  exp;
  } sb_t;

  out_t obs;
  assign obs = {state, ALUop, mem_read, mem_write, iord,
                ir_write, pc_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, pc_src,
                illegal, fault};

  sb_t  sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic efault = 1'b0;

  function automatic logic [2:0] aluop_of(logic [5:0] f);
    case (f)
      6'h22:   return 3'b001;
      6'h24:   return 3'b010;
      6'h25:   return 3'b011;
      6'h2A:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic legal(logic [31:0] ins);
    logic [5:0] op, f;
    op = ins[31:26];
    f  = ins[5:0];
    case (op)
      6'h00: return f inside {6'h20, 6'h22, 6'h24,
                              6'h25, 6'h2A};
      6'h02, 6'h04, 6'h08, 6'h23, 6'h2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic out_t exp_out(logic [3:0] st,
                                   logic [31:0] ins,
                                   logic z, logic rdy,
                                   logic flt);
    out_t o;
    o = '0;
    o.st  = st;
    o.flt = flt;
    case (st)
      4'd0: begin
        o.mr = 1; o.asb = 2'b01;
        o.irw = rdy; o.pcw = rdy;
      end
      4'd1: begin o.asb = 2'b11; o.ill = !legal(ins); end
      4'd2: begin o.asa = 1; o.asb = 2'b10; end
      4'd3: begin o.mr = 1; o.iord = 1; end
      4'd4: begin o.rw = 1; o.m2r = 1; end
      4'd5: begin o.mw = 1; o.iord = 1; end
      4'd6: begin o.asa = 1; o.aluop = aluop_of(ins[5:0]); end
      4'd7: begin o.rw = 1; o.rdst = (ins[31:26] == 6'h00); end
      4'd8: begin
        o.asa = 1; o.aluop = 3'b001;
        o.pcs = 2'b01; o.pcw = z;
      end
      4'd9:  begin o.asa = 1; o.asb = 2'b10; end
      4'd10: begin o.pcs = 2'b10; o.pcw = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic rdy);
    sb_t  e;
    out_t got;
    mem_ready = rdy;
    e.tag = tag;
    e.exp = exp_out(st, instr, zero, rdy, efault);
    sbq.push_back(e);
    #1;
    e   = sbq.pop_front();
    got = obs;
    checks++;
    assert (got === e.exp) else begin
      errors++;
      $error("FAIL %s state=%0d got %h exp %h",
             e.tag, got.st, got, e.exp);
    end
    @(negedge clk);
  endtask

  task automatic chk_v(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic rtype(input logic [31:0] ins, input string nm);
    instr = ins;
    cyc({nm, "_fetch"}, 4'd0, 1'b1);
    cyc({nm, "_dec"},   4'd1, 1'b0);
    cyc({nm, "_exe"},   4'd6, 1'b1);
    cyc({nm, "_wb"},    4'd7, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fl [5];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    #2;
    chk_v("rst_state", 32'(state), 32'd0);
    chk_v("rst_fault", 32'(fault), 32'd0);
    chk_v("rst_mw", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cyc("post_rst_fetch", 4'd0, 1'b0);
    cyc("fetch_wait", 4'd0, 1'b0);

    rtype(32'h00221820, "add");
    for (int i = 0; i < 5; i++)
      rtype({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fl[i]}, "rt");

    instr = 32'h10220003;
    zero  = 1'b1;
    cyc("beq1_fetch", 4'd0, 1'b1);
    cyc("beq1_dec", 4'd1, 1'b0);
    cyc("beq1_taken", 4'd8, 1'b0);
    zero = 1'b0;
    cyc("beq0_fetch", 4'd0, 1'b1);
    cyc("beq0_dec", 4'd1, 1'b0);
    cyc("beq0_nottaken", 4'd8, 1'b1);

    instr = 32'h20220005;
    cyc("addi_fetch", 4'd0, 1'b1);
    cyc("addi_dec", 4'd1, 1'b0);
    cyc("addi_exe", 4'd9, 1'b0);
    cyc("addi_wb", 4'd7, 1'b0);

    instr = 32'h08000010;
    cyc("j_fetch", 4'd0, 1'b1);
    cyc("j_dec", 4'd1, 1'b0);
    cyc("j_exe", 4'd10, 1'b0);

    instr = 32'h8C220004;
    cyc("lw_fetch", 4'd0, 1'b1);
    cyc("lw_dec", 4'd1, 1'b0);
    cyc("lw_adr", 4'd2, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc("lw_wait", 4'd3, 1'b0);
    cyc("lw_rd_done", 4'd3, 1'b1);
    cyc("lw_wb", 4'd4, 1'b1);

    cyc("lwb_fetch", 4'd0, 1'b1);
    cyc("lwb_dec", 4'd1, 1'b0);
    cyc("lwb_adr", 4'd2, 1'b0);
    for (int i = 0; i < 14; i++)
      cyc("lwb_wait", 4'd3, 1'b0);
    cyc("lwb_ready_at_limit", 4'd3, 1'b1);
    cyc("lwb_wb", 4'd4, 1'b0);

    instr = 32'hFC000000;
    cyc("ill_op_fetch", 4'd0, 1'b1);
    cyc("ill_op_dec", 4'd1, 1'b0);
    instr = 32'h00221827;
    cyc("ill_fn_fetch", 4'd0, 1'b1);
    cyc("ill_fn_dec", 4'd1, 1'b0);

    instr = 32'hAC220004;
    cyc("sw_fetch", 4'd0, 1'b1);
    cyc("sw_dec", 4'd1, 1'b0);
    cyc("sw_adr", 4'd2, 1'b0);
    for (int i = 0; i < 15; i++)
      cyc("sw_wait", 4'd5, 1'b0);
    efault = 1'b1;
    cyc("halt", 4'd11, 1'b0);
    cyc("halt_ready_ignored", 4'd11, 1'b1);
    cyc("halt_hold", 4'd11, 1'b0);

    #2;
    rst = 1'b1;
    #1;
    chk_v("halt_rst_state", 32'(state), 32'd0);
    chk_v("halt_rst_fault", 32'(fault), 32'd0);
    efault = 1'b0;
    #1;
    rst = 1'b0;
    @(negedge clk);

    instr = 32'h8C220004;
    cyc("lwr_fetch", 4'd0, 1'b1);
    cyc("lwr_dec", 4'd1, 1'b0);
    cyc("lwr_adr", 4'd2, 1'b0);
    cyc("lwr_wait", 4'd3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_v("mid_rst_state", 32'(state), 32'd0);
    chk_v("mid_rst_iord", 32'(iord), 32'd0);
    chk_v("mid_rst_fault", 32'(fault), 32'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    cyc("relatch_fetch", 4'd0, 1'b0);
    cyc("relatch_go", 4'd0, 1'b1);
    cyc("relatch_dec", 4'd1, 1'b0);
    cyc("relatch_adr", 4'd2, 1'b0);
    cyc("relatch_rd", 4'd3, 1'b1);
    cyc("relatch_wb", 4'd4, 1'b0);
    cyc("final_fetch", 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
